// File: rtl/screen_fetcher.sv
// Video-side initiator of the screen-fetch SRAM channel: fetches bitmap, attribute and
// optional ULAplus palette bytes one cell ahead and serialises them to the video output stage.
module screen_fetcher #(
  parameter int unsigned FLASH_BITS = 5
) (
  input  logic        clk28,
  input  logic        rst_n,
  input  logic        ck7,
  input  logic [8:0]  hc,
  input  logic [8:0]  vc,
  input  logic        frame_start,
  input  logic        up_en,
  input  logic [7:0]  vd,
  output logic        screen_fetch,
  output logic        screen_fetch_up,
  output logic [14:0] screen_addr,
  output logic [5:0]  screen_up_addr,
  output logic        pixel,
  output logic [7:0]  attr_out,
  output logic [7:0]  up_ink,
  output logic [7:0]  up_paper,
  output logic        paper_active
);

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned UPA_W  = 6;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    SLOT_NONE  = 3'd0,
    SLOT_BMP   = 3'd1,
    SLOT_ATTR  = 3'd2,
    SLOT_INK   = 3'd3,
    SLOT_PAPER = 3'd4
  } slot_e;

  logic [1:0]            r_phase;
  logic                  r_up_l;
  logic [BYTE_W-1:0]     r_bitmap_f;
  logic [BYTE_W-1:0]     r_attr_f;
  logic [BYTE_W-1:0]     r_ink_f;
  logic [BYTE_W-1:0]     r_paper_f;
  logic [BYTE_W-1:0]     r_shift;
  logic [BYTE_W-1:0]     r_attr_d;
  logic [BYTE_W-1:0]     r_up_ink;
  logic [BYTE_W-1:0]     r_up_paper;
  logic                  r_paper_active;
  logic [FLASH_BITS-1:0] r_flash_cnt;

  logic                  w_fetch_ok;
  logic [4:0]            w_x;
  logic [7:0]            w_y;
  logic                  w_cell_end;
  logic                  w_capture;
  logic                  w_flash;
  slot_e                 w_slot;

  assign w_fetch_ok = (vc < 9'd192) && (hc < 9'd256);
  assign w_x        = hc[7:3];
  assign w_y        = vc[7:0];
  assign w_cell_end = ck7 && (hc[2:0] == 3'd7);
  assign w_capture  = (r_phase == 2'd3);
  assign w_flash    = r_flash_cnt[FLASH_BITS-1];

  // Slot decode; reset forces the channel idle so an interrupted fetch is dropped at once.
  always_comb begin
    w_slot = SLOT_NONE;
    if (rst_n && w_fetch_ok) begin
      case (hc[2:0])
        3'd0:    w_slot = SLOT_BMP;
        3'd2:    w_slot = SLOT_ATTR;
        3'd4:    w_slot = r_up_l ? SLOT_INK : SLOT_NONE;
        3'd5:    w_slot = r_up_l ? SLOT_PAPER : SLOT_NONE;
        default: w_slot = SLOT_NONE;
      endcase
    end
  end

  always_comb begin
    screen_fetch    = 1'b0;
    screen_fetch_up = 1'b0;
    screen_addr     = ADDR_W'(0);
    screen_up_addr  = UPA_W'(0);
    case (w_slot)
      SLOT_BMP: begin
        screen_fetch = 1'b1;
        screen_addr  = {2'b10, w_y[7:6], w_y[2:0], w_y[5:3], w_x};
      end
      SLOT_ATTR: begin
        screen_fetch = 1'b1;
        screen_addr  = {5'b10110, w_y[7:3], w_x};
      end
      SLOT_INK: begin
        screen_fetch    = 1'b1;
        screen_fetch_up = 1'b1;
        screen_up_addr  = {r_attr_f[7:6], 1'b0, r_attr_f[2:0]};
      end
      SLOT_PAPER: begin
        screen_fetch    = 1'b1;
        screen_fetch_up = 1'b1;
        screen_up_addr  = {r_attr_f[7:6], 1'b1, r_attr_f[5:3]};
      end
      default: begin
        screen_fetch = 1'b0;
      end
    endcase
  end

  // Phase within the hc period; phase 3 coincides with ck7, the last cycle of a slot.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= 2'd0;
    end else if (ck7) begin
      r_phase <= 2'd0;
    end else begin
      r_phase <= r_phase + 2'd1;
    end
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_bitmap_f <= BYTE_W'(0);
      r_attr_f   <= BYTE_W'(0);
      r_ink_f    <= BYTE_W'(0);
      r_paper_f  <= BYTE_W'(0);
    end else if (w_capture) begin
      case (w_slot)
        SLOT_BMP:   r_bitmap_f <= vd;
        SLOT_ATTR:  r_attr_f   <= vd;
        SLOT_INK:   r_ink_f    <= vd;
        SLOT_PAPER: r_paper_f  <= vd;
        default:    r_bitmap_f <= r_bitmap_f;
      endcase
    end
  end

  // ULAplus enable only switches on a cell boundary.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_up_l <= 1'b0;
    end else if (w_cell_end) begin
      r_up_l <= up_en;
    end
  end

  // Display pipeline: load the fetched cell at its end, otherwise shift one pixel per hc.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_shift        <= BYTE_W'(0);
      r_attr_d       <= BYTE_W'(0);
      r_up_ink       <= BYTE_W'(0);
      r_up_paper     <= BYTE_W'(0);
      r_paper_active <= 1'b0;
    end else if (w_cell_end) begin
      if (w_fetch_ok) begin
        r_shift        <= r_bitmap_f;
        r_attr_d       <= r_attr_f;
        r_paper_active <= 1'b1;
        r_up_ink       <= r_up_l ? r_ink_f   : BYTE_W'(0);
        r_up_paper     <= r_up_l ? r_paper_f : BYTE_W'(0);
      end else begin
        r_shift        <= BYTE_W'(0);
        r_attr_d       <= BYTE_W'(0);
        r_paper_active <= 1'b0;
      end
    end else if (ck7) begin
      r_shift <= {r_shift[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_flash_cnt <= FLASH_BITS'(0);
    end else if (frame_start) begin
      r_flash_cnt <= r_flash_cnt + FLASH_BITS'(1);
    end
  end

  assign pixel        = r_shift[7] ^ (w_flash & r_attr_d[7] & r_paper_active);
  assign attr_out     = r_attr_d;
  assign up_ink       = r_up_ink;
  assign up_paper     = r_up_paper;
  assign paper_active = r_paper_active;

endmodule

// File: tb/tb_screen_fetcher.sv
// Directed bench for screen_fetcher: acts as timing generator and video SRAM,
// checking fetch addresses, captured cells, pixel order, ULAplus, flash and borders.
module tb_screen_fetcher;

  logic        clk28;
  logic        rst_n;
  logic        ck7;
  logic [8:0]  hc;
  logic [8:0]  vc;
  logic        frame_start;
  logic        up_en;
  logic [7:0]  vd;
  logic        screen_fetch;
  logic        screen_fetch_up;
  logic [14:0] screen_addr;
  logic [5:0]  screen_up_addr;
  logic        pixel;
  logic [7:0]  attr_out;
  logic [7:0]  up_ink;
  logic [7:0]  up_paper;
  logic        paper_active;

  logic [7:0]  vram [0:32767];
  logic [7:0]  pal  [0:63];

  int          n_checks;
  int          n_errors;
  int          fs_pend;
  logic        hold_en;
  logic [14:0] hold_addr;
  logic [7:0]  pat;

  screen_fetcher #(.FLASH_BITS(5)) dut (
    .clk28          (clk28),
    .rst_n          (rst_n),
    .ck7            (ck7),
    .hc             (hc),
    .vc             (vc),
    .frame_start    (frame_start),
    .up_en          (up_en),
    .vd             (vd),
    .screen_fetch   (screen_fetch),
    .screen_fetch_up(screen_fetch_up),
    .screen_addr    (screen_addr),
    .screen_up_addr (screen_up_addr),
    .pixel          (pixel),
    .attr_out       (attr_out),
    .up_ink         (up_ink),
    .up_paper       (up_paper),
    .paper_active   (paper_active)
  );

  assign vd = screen_fetch_up ? pal[screen_up_addr] : vram[screen_addr];

  initial clk28 = 1'b0;
  always #5 clk28 = ~clk28;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One hc period of 4 clk28; ck7 on the last cycle, hc advances after it.
  task automatic hc_step();
    for (int s = 0; s < 4; s++) begin
      ck7 = (s == 3);
      frame_start = (s == 0) && (fs_pend > 0);
      if (frame_start) fs_pend--;
      #1;
      if (hold_en) begin
        chk("hold_fetch", 32'(screen_fetch), 32'd1);
        chk("hold_addr", 32'(screen_addr), 32'(hold_addr));
      end
      @(posedge clk28);
      #1;
    end
    ck7 = 1'b0;
    frame_start = 1'b0;
    if (hc == 9'd447) begin
      hc = 9'd0;
      vc = vc + 9'd1;
    end else begin
      hc = hc + 9'd1;
    end
  endtask

  task automatic run_to(input logic [8:0] target);
    int steps;
    steps = 0;
    while (hc != target && steps < 500) begin
      hc_step();
      steps++;
    end
    chk("run_to_reach", 32'(hc), 32'(target));
    #1;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    fs_pend     = 0;
    hold_en     = 1'b0;
    hold_addr   = 15'h0;
    rst_n       = 1'b0;
    ck7         = 1'b0;
    hc          = 9'd0;
    vc          = 9'd0;
    frame_start = 1'b0;
    up_en       = 1'b0;
    for (int i = 0; i < 32768; i++) vram[i] = 8'(i);
    for (int i = 0; i < 64; i++) pal[i] = 8'(i * 3 + 1);
    vram[15'h5800] = 8'h3C;
    vram[15'h4905] = 8'hA5;
    vram[15'h5905] = 8'h47;
    vram[15'h5907] = 8'hC5;
    vram[15'h490A] = 8'hFF;
    vram[15'h590A] = 8'h80;
    vram[15'h490D] = 8'hFF;
    vram[15'h590D] = 8'h80;
    vram[15'h5AFF] = 8'h07;

    // Reset state while hc/vc sit on a bitmap slot
    repeat (3) @(posedge clk28);
    #1;
    chk("rst_fetch", 32'(screen_fetch), 32'd0);
    chk("rst_addr", 32'(screen_addr), 32'd0);
    chk("rst_pixel", 32'(pixel), 32'd0);
    chk("rst_attr", 32'(attr_out), 32'd0);
    chk("rst_paper", 32'(paper_active), 32'd0);
    chk("rst_ink", 32'(up_ink), 32'd0);
    chk("rst_upaper", 32'(up_paper), 32'd0);
    rst_n = 1'b1;

    // First cell of line 0
    hold_en = 1'b1;
    hold_addr = 15'h4000;
    hc_step();
    hold_en = 1'b0;
    run_to(9'd2);
    chk("l0_attr_fetch", 32'(screen_fetch), 32'd1);
    chk("l0_attr_addr", 32'(screen_addr), 32'h5800);
    chk("l0_attr_up", 32'(screen_fetch_up), 32'd0);
    run_to(9'd4);
    chk("l0_no_ink", 32'(screen_fetch), 32'd0);
    chk("l0_no_up", 32'(screen_fetch_up), 32'd0);
    run_to(9'd8);
    chk("l0_paper", 32'(paper_active), 32'd1);
    chk("l0_attr_out", 32'(attr_out), 32'h3C);
    chk("l0_pixel", 32'(pixel), 32'd0);

    // Line 65, column 5
    vc = 9'd65;
    hc = 9'd40;
    #1;
    chk("l65_bmp_addr", 32'(screen_addr), 32'h4905);
    run_to(9'd42);
    chk("l65_attr_addr", 32'(screen_addr), 32'h5905);
    run_to(9'd44);
    chk("l65_no_ink", 32'(screen_fetch), 32'd0);
    run_to(9'd48);
    up_en = 1'b1;
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("l65_pixel", 32'(pixel), 32'(pat[7-i]));
      if (i == 0) begin
        chk("l65_attr_out", 32'(attr_out), 32'h47);
        chk("l65_paper", 32'(paper_active), 32'd1);
      end
      hc_step();
    end

    // ULAplus palette fetches for column 7 (attr 0xC5)
    run_to(9'd60);
    chk("up_ink_fetch", 32'(screen_fetch), 32'd1);
    chk("up_ink_up", 32'(screen_fetch_up), 32'd1);
    chk("up_ink_addr", 32'(screen_up_addr), 32'h35);
    run_to(9'd61);
    chk("up_pap_up", 32'(screen_fetch_up), 32'd1);
    chk("up_pap_addr", 32'(screen_up_addr), 32'h38);
    run_to(9'd62);
    chk("up_idle", 32'(screen_fetch), 32'd0);
    run_to(9'd64);
    chk("up_ink_out", 32'(up_ink), 32'hA0);
    chk("up_pap_out", 32'(up_paper), 32'hA9);
    chk("up_attr_out", 32'(attr_out), 32'hC5);
    chk("up_pixel", 32'(pixel), 32'd0);
    run_to(9'd66);
    up_en = 1'b0;
    run_to(9'd68);
    chk("up_midcell_up", 32'(screen_fetch_up), 32'd1);
    chk("up_midcell_addr", 32'(screen_up_addr), 32'h00);
    run_to(9'd72);
    chk("up_ink_c8", 32'(up_ink), 32'h01);
    chk("up_pap_c8", 32'(up_paper), 32'h1C);
    fs_pend = 16;
    run_to(9'd76);
    chk("up_off_fetch", 32'(screen_fetch), 32'd0);
    run_to(9'd80);
    chk("up_off_ink", 32'(up_ink), 32'd0);
    chk("up_off_pap", 32'(up_paper), 32'd0);

    // Flash: 16 pulses invert ink cell, 16 more restore it
    run_to(9'd88);
    fs_pend = 16;
    chk("fl_attr", 32'(attr_out), 32'h80);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("fl_on_pixel", 32'(pixel), 32'd0);
      hc_step();
    end
    run_to(9'd112);
    chk("fl_attr2", 32'(attr_out), 32'h80);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("fl_off_pixel", 32'(pixel), 32'd1);
      hc_step();
    end

    // Last paper line, last column, then border
    vc = 9'd191;
    hc = 9'd248;
    #1;
    chk("last_bmp_addr", 32'(screen_addr), 32'h57FF);
    run_to(9'd250);
    chk("last_attr_addr", 32'(screen_addr), 32'h5AFF);
    run_to(9'd255);
    chk("h255_fetch", 32'(screen_fetch), 32'd0);
    run_to(9'd256);
    chk("h256_fetch", 32'(screen_fetch), 32'd0);
    chk("h256_paper", 32'(paper_active), 32'd1);
    chk("h256_pixel", 32'(pixel), 32'd1);
    chk("h256_attr", 32'(attr_out), 32'h07);
    run_to(9'd258);
    chk("h258_fetch", 32'(screen_fetch), 32'd0);
    run_to(9'd264);
    chk("border_paper", 32'(paper_active), 32'd0);
    chk("border_pixel", 32'(pixel), 32'd0);
    chk("border_attr", 32'(attr_out), 32'd0);
    hc = 9'd440;
    #1;
    chk("h440_fetch", 32'(screen_fetch), 32'd0);
    run_to(9'd0);
    chk("vc192_line", 32'(vc), 32'd192);
    chk("vc192_bmp", 32'(screen_fetch), 32'd0);
    run_to(9'd2);
    chk("vc192_attr", 32'(screen_fetch), 32'd0);
    run_to(9'd8);
    chk("vc192_paper", 32'(paper_active), 32'd0);

    // Reset in the middle of an attribute slot
    vc = 9'd0;
    hc = 9'd2;
    ck7 = 1'b0;
    #1;
    chk("mid_attr_pre", 32'(screen_addr), 32'h5800);
    @(posedge clk28);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_fetch", 32'(screen_fetch), 32'd0);
    chk("mid_rst_addr", 32'(screen_addr), 32'd0);
    @(posedge clk28);
    @(posedge clk28);
    #1;
    hc = 9'd3;
    rst_n = 1'b1;
    run_to(9'd8);
    chk("mid_rst_attr", 32'(attr_out), 32'd0);
    chk("mid_rst_paper", 32'(paper_active), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
